// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter.
// Queues command bytes in a small FIFO and sends each one over the
// open-drain PS/2 clock/data pair. Each frame is: inhibit, request-to-send,
// 8 data bits LSB first, odd parity, stop, then the device acknowledge.
module ps2_host_transmitter #(
   parameter int FIFO_AW        = 3,
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       system_clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       full,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout_err
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [INH_W-1:0]   INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [FIFO_AW:0]   FIFO_FULL = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

   // line synchroniser
   logic clk_meta, clk_sync, clk_prev;
   logic data_meta, data_sync;
   logic fall;

   // command FIFO
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   count;
   logic [7:0]         head;
   logic               push, pop;

   // frame engine
   state_t             state_q, state_d;
   logic [7:0]         shift_q, shift_d;
   logic               par_q, par_d;
   logic [3:0]         bit_cnt_q, bit_cnt_d;
   logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
   logic [TMO_W-1:0]   timer_q, timer_d;
   logic               clk_oe_q, clk_oe_d;
   logic               data_oe_q, data_oe_d;
   logic               ack_ok_q, ack_ok_d;
   logic               done_q, done_d;
   logic               ack_err_q, ack_err_d;
   logic               tmo_q, tmo_d;

   // Two-flop synchronise both PS/2 lines; idle level of the bus is high.
   always_ff @(posedge system_clk or negedge reset) begin
      if (!reset) begin
         clk_meta  <= 1'b1;
         clk_sync  <= 1'b1;
         clk_prev  <= 1'b1;
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         clk_meta  <= ps2_clk_in;
         clk_sync  <= clk_meta;
         clk_prev  <= clk_sync;
         data_meta <= ps2_data_in;
         data_sync <= data_meta;
      end
   end

   assign fall = clk_prev & ~clk_sync;

   assign full = (count == FIFO_FULL);
   assign push = wr_en & (~full | pop);
   assign head = mem[rd_ptr];

   // FIFO storage holds data only, so it needs no reset.
   always_ff @(posedge system_clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // FIFO pointers and occupancy; a pop frees the slot a simultaneous push uses.
   always_ff @(posedge system_clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (FIFO_AW + 1)'(1);
            2'b01:   count <= count - (FIFO_AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Frame engine state and registered line drives / status pulses.
   always_ff @(posedge system_clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         par_q     <= 1'b0;
         bit_cnt_q <= '0;
         inh_cnt_q <= '0;
         timer_q   <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         ack_ok_q  <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         bit_cnt_q <= bit_cnt_d;
         inh_cnt_q <= inh_cnt_d;
         timer_q   <= timer_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         ack_ok_q  <= ack_ok_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
         tmo_q     <= tmo_d;
      end
   end

   // Next-state logic: sequence one frame, with the timeout overriding any phase.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      par_d     = par_q;
      bit_cnt_d = bit_cnt_q;
      inh_cnt_d = inh_cnt_q;
      timer_d   = timer_q;
      data_oe_d = data_oe_q;
      ack_ok_d  = ack_ok_q;
      done_d    = 1'b0;
      ack_err_d = 1'b0;
      tmo_d     = 1'b0;
      pop       = 1'b0;

      case (state_q)
         IDLE: begin
            data_oe_d = 1'b0;
            if (count != '0) begin
               pop       = 1'b1;
               shift_d   = head;
               par_d     = ~^head;
               ack_ok_d  = 1'b0;
               inh_cnt_d = '0;
               state_d   = INHIBIT;
            end
         end
         INHIBIT: begin
            if (inh_cnt_q == INH_LAST) begin
               data_oe_d = 1'b1;
               state_d   = REQ;
            end else begin
               inh_cnt_d = inh_cnt_q + INH_W'(1);
            end
         end
         REQ: begin
            bit_cnt_d = '0;
            timer_d   = '0;
            state_d   = SEND;
         end
         SEND: begin
            if (fall) begin
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q < 4'd8) begin
                  data_oe_d = ~shift_q[bit_cnt_q[2:0]];
               end else if (bit_cnt_q == 4'd8) begin
                  data_oe_d = ~par_q;
               end else begin
                  data_oe_d = 1'b0;
                  state_d   = ACK;
               end
            end
         end
         ACK: begin
            if (fall) begin
               ack_ok_d  = ~data_sync;
               ack_err_d = data_sync;
               state_d   = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (clk_sync && data_sync) begin
               done_d  = ack_ok_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Device-paced phases are bounded from the moment the clock is released.
      if (state_q == SEND || state_q == ACK || state_q == WAIT_IDLE) begin
         timer_d = timer_q + TMO_W'(1);
         if (timer_q == TMO_LAST) begin
            state_d   = IDLE;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            ack_err_d = 1'b0;
            tmo_d     = 1'b1;
         end
      end

      clk_oe_d = (state_d == INHIBIT) || (state_d == REQ);
   end

   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign ack_err     = ack_err_q;
   assign timeout_err = tmo_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: open-drain bus plus a behavioural PS/2
// device that clocks frames in, records the ten host-driven bits and acks.
module tb_ps2_host_transmitter;

   localparam int H = 4;   // device clock half period in system_clk cycles

   logic       system_clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err;
   logic       dev_clk = 1'b1, dev_data = 1'b1;
   logic       clk_line, data_line;
   logic       dev_en, dev_ack_ok;
   int         dev_falls = 0;
   logic [9:0] frames_q [$];

   assign clk_line  = dev_clk & ~ps2_clk_oe;
   assign data_line = dev_data & ~ps2_data_oe;

   always #5 system_clk = ~system_clk;

   ps2_host_transmitter #(
      .FIFO_AW(3), .INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(200)
   ) dut (
      .system_clk(system_clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .ps2_clk_in(clk_line), .ps2_data_in(data_line),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
      .done(done), .ack_err(ack_err), .timeout_err(timeout_err)
   );

   // PS/2 device: on request-to-send, give 11 clocks, capture bits, ack on the 11th.
   initial begin
      logic [9:0] cap;
      logic       ack_mode;
      forever begin
         @(negedge system_clk);
         if (dev_en && clk_line && !data_line) begin
            ack_mode = dev_ack_ok;
            cap = '0;
            repeat (2) @(negedge system_clk);
            for (int k = 1; k <= 11; k++) begin
               if (k >= 2) cap[k-2] = data_line;
               if (k == 11 && ack_mode) dev_data = 1'b0;
               dev_clk = 1'b0;
               dev_falls = k;
               repeat (H) @(negedge system_clk);
               dev_clk = 1'b1;
               repeat (H) @(negedge system_clk);
            end
            dev_data = 1'b1;
            repeat (2) @(negedge system_clk);
            frames_q.push_back(cap);
         end
      end
   end

   // Monitors: pulse counts, pulse rules, inhibit length, release-to-timeout distance.
   int   cyc = 0, done_n = 0, ackerr_n = 0, tmo_n = 0, viol = 0;
   int   inh_run = 0, last_inh = 0, rel_cyc = 0, tmo_cyc = 0;
   logic [2:0] tmo_lines = '0;
   logic p_done = 0, p_ack = 0, p_tmo = 0, p_doe = 0, p_coe = 0;
   always @(negedge system_clk) begin
      cyc      <= cyc + 1;
      done_n   <= done_n + int'(done);
      ackerr_n <= ackerr_n + int'(ack_err);
      tmo_n    <= tmo_n + int'(timeout_err);
      if (int'(done) + int'(ack_err) + int'(timeout_err) > 1) viol <= viol + 1;
      else if ((done && p_done) || (ack_err && p_ack) || (timeout_err && p_tmo)) viol <= viol + 1;
      if (!ps2_clk_oe) inh_run <= 0;
      else if (!ps2_data_oe) inh_run <= inh_run + 1;
      else if (!p_doe) last_inh <= inh_run;
      if (p_coe && !ps2_clk_oe) rel_cyc <= cyc;
      if (timeout_err) begin
         tmo_cyc   <= cyc;
         tmo_lines <= {ps2_clk_oe, ps2_data_oe, busy};
      end
      p_done <= done; p_ack <= ack_err; p_tmo <= timeout_err;
      p_doe  <= ps2_data_oe; p_coe <= ps2_clk_oe;
   end

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push(input logic [7:0] b);
      wr_en = 1'b1;
      wr_data = b;
      @(negedge system_clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int budget, input string name);
      int c = 0;
      while (frames_q.size() < target && c < budget) begin
         @(negedge system_clk);
         c++;
      end
      chk(name, 32'(frames_q.size() >= target), 32'd1);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int c = 0;
      while (busy && c < budget) begin
         @(negedge system_clk);
         c++;
      end
      chk(name, 32'(busy), 32'd0);
      repeat (3) @(negedge system_clk);
   endtask

   function automatic logic [9:0] frame_at(input int idx);
      return (idx < frames_q.size()) ? frames_q[idx] : 10'h000;
   endfunction

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // {stop, parity, d7..d0} as seen on the data line
   } vec_t;

   vec_t       vecs [5];
   logic [7:0] order [9];
   int         f0, d0, a0, t0, c, bad;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'hED, 10'h3ED};
      vecs[1] = '{8'h01, 10'h201};
      vecs[2] = '{8'hFF, 10'h3FF};
      vecs[3] = '{8'h00, 10'h300};
      vecs[4] = '{8'hF4, 10'h2F4};
      order[0] = 8'h11;
      for (int i = 1; i < 9; i++) order[i] = 8'h80 + 8'(i - 1);

      reset = 1'b0; wr_en = 1'b0; wr_data = '0; dev_en = 1'b1; dev_ack_ok = 1'b1;
      repeat (3) @(negedge system_clk);
      chk("reset_outputs", {25'd0, full, busy, ps2_clk_oe, ps2_data_oe, done, ack_err, timeout_err}, 32'd0);
      reset = 1'b1;
      repeat (3) @(negedge system_clk);
      chk("idle_after_reset", {25'd0, full, busy, ps2_clk_oe, ps2_data_oe, done, ack_err, timeout_err}, 32'd0);

      // Normal frames with ack
      for (int i = 0; i < 5; i++) begin
         f0 = frames_q.size(); d0 = done_n; a0 = ackerr_n; t0 = tmo_n;
         push(vecs[i].data);
         wait_frames(f0 + 1, 400, "frame_wait");
         wait_idle(100, "busy_clear");
         chk("frame_bits", 32'(frame_at(f0)), 32'(vecs[i].frame));
         chk("done_pulse", done_n - d0, 1);
         chk("no_ack_err", ackerr_n - a0, 0);
         chk("no_timeout", tmo_n - t0, 0);
         chk("inhibit_len", last_inh, 20);
      end

      // Ack bit held high, then the next queued byte goes out normally
      f0 = frames_q.size(); d0 = done_n; a0 = ackerr_n;
      dev_ack_ok = 1'b0;
      push(8'h55);
      push(8'h3C);
      wait_frames(f0 + 1, 400, "nack_frame_wait");
      dev_ack_ok = 1'b1;
      repeat (3) @(negedge system_clk);
      chk("nack_ack_err", ackerr_n - a0, 1);
      chk("nack_no_done", done_n - d0, 0);
      wait_frames(f0 + 2, 400, "after_nack_wait");
      wait_idle(100, "after_nack_idle");
      chk("nack_frame", 32'(frame_at(f0)), 32'h355);
      chk("after_nack_frame", 32'(frame_at(f0 + 1)), 32'h33C);
      chk("after_nack_done", done_n - d0, 1);
      chk("after_nack_ack_err", ackerr_n - a0, 1);

      // Stalled device: fill the FIFO, drop a ninth push, then drain in order
      dev_en = 1'b0;
      f0 = frames_q.size();
      push(order[0]);
      for (int i = 1; i < 9; i++) push(order[i]);
      repeat (2) @(negedge system_clk);
      chk("full_when_8_queued", 32'(full), 32'd1);
      push(8'h99);
      chk("full_after_drop", 32'(full), 32'd1);
      dev_en = 1'b1;
      wait_frames(f0 + 9, 2500, "drain_wait");
      wait_idle(200, "drain_idle");
      for (int i = 0; i < 9; i++) chk("drain_order", 32'(frame_at(f0 + i) & 10'h2FF), 32'({2'b10, order[i]}));
      repeat (300) @(negedge system_clk);
      chk("dropped_not_sent", frames_q.size() - f0, 9);
      chk("fifo_empty_full", 32'(full), 32'd0);

      // Device never clocks: timeout after exactly TIMEOUT_CYCLES
      dev_en = 1'b0;
      d0 = done_n; a0 = ackerr_n; t0 = tmo_n;
      push(8'h42);
      c = 0;
      while (tmo_n == t0 && c < 400) begin
         @(negedge system_clk);
         c++;
      end
      repeat (2) @(negedge system_clk);
      chk("timeout_pulse", tmo_n - t0, 1);
      chk("timeout_distance", tmo_cyc - rel_cyc, 200);
      chk("timeout_lines", 32'(tmo_lines), 32'd0);
      chk("timeout_no_done", done_n - d0, 0);
      chk("timeout_no_ack_err", ackerr_n - a0, 0);
      dev_en = 1'b1;
      repeat (5) @(negedge system_clk);

      // Reset mid-frame after the fifth device clock fall
      push(8'hED);
      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
      c = 0;
      while (dev_falls != 5 && c < 300) begin
         @(negedge system_clk);
         c++;
      end
      repeat (4) @(negedge system_clk);
      chk("pre_reset_state", {29'd0, full, busy, ps2_data_oe}, 32'h7);
      #2 reset = 1'b0;
      #1 chk("reset_async_release", {28'd0, ps2_clk_oe, ps2_data_oe, busy, full}, 32'd0);
      repeat (3) @(negedge system_clk);
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge system_clk);
         if (busy || ps2_clk_oe || ps2_data_oe || full) bad++;
      end
      chk("stays_idle_after_reset", bad, 0);

      chk("pulse_rules", viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
